// File: rtl/aes_round_controller.sv
// Sequencer for the iterative AES-128 round datapath: initial key-add, mixed rounds, final round.
// Optional abort input enabled by defining AES_ABORT_EN.
module aes_round_controller #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned ROUND_LAT  = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       key_ready,
`ifdef AES_ABORT_EN
    input  logic       abort,
`endif
    output logic       key_req,
    output logic       sel_init,
    output logic       mix_enable,
    output logic       state_load,
    output logic [3:0] round_cnt,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

    localparam logic [1:0] SettleLast = 2'(ROUND_LAT - 1);
    localparam logic [3:0] LastRound  = 4'(NUM_ROUNDS);

    state_e     stateQ, stateD;
    logic [3:0] roundD;
    logic [1:0] settleQ, settleD;
    logic       abortHit;

    // key_req is high exactly in the states where abort is honoured.
`ifdef AES_ABORT_EN
    assign abortHit = abort && key_req;
`else
    assign abortHit = 1'b0;
`endif

    assign state_load = key_req && key_ready && (settleQ == SettleLast) && !abortHit;

    always_comb begin
        stateD  = stateQ;
        roundD  = round_cnt;
        settleD = settleQ;
        if (abortHit) begin
            stateD  = StIdle;
            roundD  = 4'd0;
            settleD = 2'd0;
        end else begin
            // Settle count only advances while the key is valid, so a stall keeps progress.
            if (key_req) begin
                if (state_load) begin
                    settleD = 2'd0;
                end else if (key_ready) begin
                    settleD = 2'(settleQ + 2'd1);
                end
            end
            unique case (stateQ)
                StIdle: begin
                    if (start) begin
                        stateD  = StInit;
                        roundD  = 4'd0;
                        settleD = 2'd0;
                    end
                end
                StInit: begin
                    if (state_load) begin
                        stateD = StRound;
                        roundD = 4'd1;
                    end
                end
                StRound: begin
                    if (state_load) begin
                        roundD = 4'(round_cnt + 4'd1);
                        if (roundD == LastRound) begin
                            stateD = StFinal;
                        end
                    end
                end
                StFinal: begin
                    if (state_load) begin
                        stateD = StDone;
                    end
                end
                StDone:  stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with stateQ.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stateQ     <= StIdle;
            round_cnt  <= 4'd0;
            settleQ    <= 2'd0;
            key_req    <= 1'b0;
            sel_init   <= 1'b0;
            mix_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            stateQ     <= stateD;
            round_cnt  <= roundD;
            settleQ    <= settleD;
            key_req    <= (stateD == StInit) || (stateD == StRound) || (stateD == StFinal);
            sel_init   <= (stateD == StInit);
            mix_enable <= (stateD == StRound);
            busy       <= (stateD != StIdle);
            done       <= (stateD == StDone);
        end
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller; a second instance runs with ROUND_LAT=3.
// Abort checks are compiled in when AES_ABORT_EN is defined.
module tb_aes_round_controller;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       start3;
    logic       keyReady;
`ifdef AES_ABORT_EN
    logic       abort;
`endif

    logic       keyReq, selInit, mixEnable, stateLoad, busy, done;
    logic [3:0] roundCnt;
    logic       keyReq3, selInit3, mixEnable3, stateLoad3, busy3, done3;
    logic [3:0] roundCnt3;
    logic [9:0] obs1, obs3;

    int checks = 0;
    int errors = 0;

    assign obs1 = {stateLoad, selInit, mixEnable, busy, done, keyReq, roundCnt};
    assign obs3 = {stateLoad3, selInit3, mixEnable3, busy3, done3, keyReq3, roundCnt3};

    aes_round_controller dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .key_ready  (keyReady),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .key_req    (keyReq),
        .sel_init   (selInit),
        .mix_enable (mixEnable),
        .state_load (stateLoad),
        .round_cnt  (roundCnt),
        .busy       (busy),
        .done       (done)
    );

    aes_round_controller #(.NUM_ROUNDS(10), .ROUND_LAT(3)) dut3 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start3),
        .key_ready  (keyReady),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .key_req    (keyReq3),
        .sel_init   (selInit3),
        .mix_enable (mixEnable3),
        .state_load (stateLoad3),
        .round_cnt  (roundCnt3),
        .busy       (busy3),
        .done       (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        keyReady = 1'b0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        checks++;
        if (obs1 !== 10'd0) begin
            errors++;
            $display("FAIL reset_dut: got %b want %b", obs1, 10'd0);
        end
        checks++;
        if (obs3 !== 10'd0) begin
            errors++;
            $display("FAIL reset_dut3: got %b want %b", obs3, 10'd0);
        end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_midrun();
        int loads;
        int dones;
        keyReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #1;
        checks++;
        if (obs1 !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL midrun_round5: got %b want %b", obs1,
                     {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5});
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (obs1 !== 10'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %b want %b", obs1, 10'd0);
        end
        #2;
        n_rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        loads = 0;
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            #1;
            if (stateLoad) loads++;
            if (done) dones++;
            tick();
        end
        checks++;
        if (loads != 11 || dones != 1) begin
            errors++;
            $display("FAIL after_reset_run: got loads %0d dones %0d want 11 1", loads, dones);
        end
    endtask

    task automatic test_nominal();
        logic [9:0] exp;
        keyReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            #1;
            if (n <= 11)
                exp = {1'b1, n == 1, n >= 2 && n <= 10, 1'b1, 1'b0, 1'b1, 4'(n - 1)};
            else if (n == 12)
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10};
            else
                exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10};
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL nominal cycle %0d: got %b want %b", n, obs1, exp);
            end
            tick();
        end
    endtask

    task automatic test_key_stall();
        logic [9:0] exp;
        int rc;
        start = 1'b1;
        keyReady = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            keyReady = !(n >= 5 && n <= 7);
            #1;
            rc = (n <= 4) ? n - 1 : ((n <= 7) ? 4 : n - 4);
            if (n <= 14)
                exp = {!(n >= 5 && n <= 7), rc == 0, rc >= 1 && rc <= 9, 1'b1, 1'b0, 1'b1,
                       4'(rc)};
            else if (n == 15)
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10};
            else
                exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10};
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL key_stall cycle %0d: got %b want %b", n, obs1, exp);
            end
            tick();
        end
        keyReady = 1'b1;
    endtask

    task automatic test_round_lat3();
        logic [9:0] exp;
        int rc;
        int waited;
        keyReady = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            #1;
            rc = (n - 1) / 3;
            if (n <= 33)
                exp = {n % 3 == 0, rc == 0, rc >= 1 && rc <= 9, 1'b1, 1'b0, 1'b1, 4'(rc)};
            else if (n == 34)
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10};
            else
                exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10};
            checks++;
            if (obs3 !== exp) begin
                errors++;
                $display("FAIL lat3 cycle %0d: got %b want %b", n, obs3, exp);
            end
            tick();
        end
        // Drop key_ready mid-settle: the count must hold, delaying the first load by one cycle.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            keyReady = (n != 2);
            #1;
            checks++;
            if (stateLoad3 !== (n == 4) || roundCnt3 !== ((n <= 4) ? 4'd0 : 4'd1)) begin
                errors++;
                $display("FAIL lat3_stall cycle %0d: got load %b rc %0d want load %b rc %0d",
                         n, stateLoad3, roundCnt3, n == 4, (n <= 4) ? 0 : 1);
            end
            tick();
        end
        keyReady = 1'b1;
        waited = 0;
        while (busy3 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (busy3 !== 1'b0) begin
            errors++;
            $display("FAIL lat3_drain: got busy %b want 0", busy3);
        end
    endtask

    task automatic test_start_busy();
        int dones;
        keyReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            start = (n == 7);
            #1;
            if (done) dones++;
            if (n == 13) begin
                checks++;
                if (busy !== 1'b0 || roundCnt !== 4'd10) begin
                    errors++;
                    $display("FAIL start_busy_idle: got busy %b rc %0d want 0 10", busy, roundCnt);
                end
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL start_busy_dones: got %0d want 1", dones);
        end
        // Start held high: one IDLE cycle between done and the next INIT.
        start = 1'b1;
        tick();
        for (int n = 1; n <= 26; n++) begin
            if (n == 26) start = 1'b0;
            #1;
            if (n == 12 || n == 25) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL held_done cycle %0d: got %b want 1", n, done);
                end
            end
            if (n == 13 || n == 26) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL held_idle cycle %0d: got busy %b done %b want 0 0", n, busy, done);
                end
            end
            if (n == 14) begin
                checks++;
                if ({selInit, busy, roundCnt} !== {1'b1, 1'b1, 4'd0}) begin
                    errors++;
                    $display("FAIL held_restart: got %b want %b", {selInit, busy, roundCnt},
                             {1'b1, 1'b1, 4'd0});
                end
            end
            tick();
        end
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        int dones;
        int waited;
        keyReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        #1;
        checks++;
        if (stateLoad !== 1'b0 || roundCnt !== 4'd7) begin
            errors++;
            $display("FAIL abort_no_load: got load %b rc %0d want 0 7", stateLoad, roundCnt);
        end
        tick();
        abort = 1'b0;
        #1;
        checks++;
        if (obs1 !== 10'd0) begin
            errors++;
            $display("FAIL abort_idle: got %b want %b", obs1, 10'd0);
        end
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            if (done) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d want 0", dones);
        end
        // Abort while idle must not block a start.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({selInit, busy, roundCnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL abort_in_idle: got %b want %b", {selInit, busy, roundCnt},
                     {1'b1, 1'b1, 4'd0});
        end
        waited = 0;
        while (busy && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain: got busy %b want 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midrun();
        test_nominal();
        test_key_stall();
        test_round_lat3();
        test_start_busy();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
